// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic ops, iterative shifts and shift-add multiply.
// Operands are latched on accept; result and flags update only on the edge entering DONE.
//
// state | meaning
// IDLE  | waiting for start; fast ops compute here and go straight to DONE
// EXEC  | one shift or multiply step per cycle, count runs down to terminal count 1
// DONE  | done pulse; result and flags valid; back to IDLE next cycle
module alu_seq #(
   parameter int N = 8,
   localparam int SW = $clog2(N)
) (
   input  logic         clock,
   input  logic         resetn,
   input  logic         start,
   input  logic [2:0]   op,
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         cin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] result,
   output logic         cout,
   output logic         zero,
   output logic         neg,
   output logic         ovf
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t         state, state_nxt;
   logic [2:0]     op_q;
   logic [2*N-1:0] acc;
   logic [2*N-1:0] mcand;
   logic [N-1:0]   mplier;
   logic [SW:0]    count;

   logic           accept;
   logic           fast;
   logic           last_step;
   logic [SW-1:0]  s_amt;
   logic [N-1:0]   y_eff;
   logic [N:0]     sum;
   logic [N-1:0]   fast_res;
   logic           fast_c;
   logic           fast_v;
   logic [N-1:0]   shift_val;
   logic           shift_c;
   logic [2*N-1:0] acc_mul;
   logic [N-1:0]   exec_res;
   logic           exec_c;
   logic           exec_v;
   logic           wr_en;
   logic [N-1:0]   wr_res;
   logic           wr_c;
   logic           wr_v;

   assign s_amt     = y[SW-1:0];
   assign accept    = (state == IDLE) && start;
   assign last_step = (count == {{SW{1'b0}}, 1'b1});
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);

   always_comb begin
      y_eff    = (op == OP_SUB) ? ~y : y;
      sum      = {1'b0, x} + {1'b0, y_eff} + {{N{1'b0}}, cin};
      fast_res = x;
      fast_c   = 1'b0;
      fast_v   = 1'b0;
      fast     = 1'b0;
      case (op)
         OP_ADD, OP_SUB: begin
            fast_res = sum[N-1:0];
            fast_c   = sum[N];
            fast_v   = (x[N-1] == y_eff[N-1]) && (sum[N-1] != x[N-1]);
            fast     = 1'b1;
         end
         OP_AND: begin
            fast_res = x & y;
            fast     = 1'b1;
         end
         OP_OR: begin
            fast_res = x | y;
            fast     = 1'b1;
         end
         OP_XOR: begin
            fast_res = x ^ y;
            fast     = 1'b1;
         end
         OP_SHL, OP_SHR: fast = (s_amt == '0);
         default:        fast = 1'b0;
      endcase
   end

   always_comb begin
      if (op_q == OP_SHL) begin
         shift_val = {acc[N-2:0], 1'b0};
         shift_c   = acc[N-1];
      end else begin
         shift_val = {1'b0, acc[N-1:1]};
         shift_c   = acc[0];
      end
      acc_mul = acc + (mplier[0] ? mcand : '0);
      if (op_q == OP_MUL) begin
         exec_res = acc_mul[N-1:0];
         exec_c   = |acc_mul[2*N-1:N];
         exec_v   = |acc_mul[2*N-1:N];
      end else begin
         exec_res = shift_val;
         exec_c   = shift_c;
         exec_v   = 1'b0;
      end
   end

   always_comb begin
      wr_en  = 1'b0;
      wr_res = exec_res;
      wr_c   = exec_c;
      wr_v   = exec_v;
      if (accept && fast) begin
         wr_en  = 1'b1;
         wr_res = fast_res;
         wr_c   = fast_c;
         wr_v   = fast_v;
      end else if ((state == EXEC) && last_step) begin
         wr_en  = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = fast ? DONE : EXEC;
         EXEC:    if (last_step) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         op_q   <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         count  <= '0;
      end else if (accept) begin
         op_q   <= op;
         mcand  <= {{N{1'b0}}, x};
         mplier <= y;
         if (op == OP_MUL) begin
            acc   <= '0;
            count <= (SW+1)'(N);
         end else begin
            acc   <= {{N{1'b0}}, x};
            count <= {1'b0, s_amt};
         end
      end else if (state == EXEC) begin
         count <= count - 1'b1;
         if (op_q == OP_MUL) begin
            acc    <= acc_mul;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
         end else begin
            acc    <= {{N{1'b0}}, shift_val};
         end
      end
   end

   // Status registers reset to all-zero, including zero, so nothing looks valid before the first op.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         result <= '0;
         cout   <= 1'b0;
         zero   <= 1'b0;
         neg    <= 1'b0;
         ovf    <= 1'b0;
      end else if (wr_en) begin
         result <= wr_res;
         cout   <= wr_c;
         zero   <= (wr_res == '0);
         neg    <= wr_res[N-1];
         ovf    <= wr_v;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=8): latency, result/flags, ignored start, reset abort, back-to-back.
module tb_alu_seq;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       start = 1'b0;
   logic [2:0] op = 3'b000;
   logic [7:0] x = 8'h00;
   logic [7:0] y = 8'h00;
   logic       cin = 1'b0;
   logic       busy, done, cout, zero, neg, ovf;
   logic [7:0] result;

   int         n_checks = 0;
   int         n_pass = 0;
   logic [7:0] prev_res = 8'h00;

   alu_seq #(.N(8)) dut (
      .clock  (clock),
      .resetn (resetn),
      .start  (start),
      .op     (op),
      .x      (x),
      .y      (y),
      .cin    (cin),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .zero   (zero),
      .neg    (neg),
      .ovf    (ovf)
   );

   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Issues one op, scrambles inputs after acceptance, and checks latency, hold and flags.
   // poke > 0 drives a stray ADD start during that busy cycle.
   task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic ci, input int exp_lat,
                         input logic [7:0] er, input logic ec, input logic ev, input int poke);
      int   lat;
      logic busy_ok;
      logic hold_ok;
      @(negedge clock);
      op = o; x = a; y = b; cin = ci; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      x = 8'($urandom);
      y = 8'($urandom);
      op = 3'($urandom);
      cin = 1'($urandom);
      lat = 0;
      busy_ok = 1'b1;
      hold_ok = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = c;
            break;
         end
         if (result !== prev_res) hold_ok = 1'b0;
         if (c == poke) begin
            start = 1'b1; op = OP_ADD; x = 8'h01; y = 8'h01; cin = 1'b0;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check_val($sformatf("%s latency", tag), 16'(lat), 16'(exp_lat));
      check_val($sformatf("%s busy", tag), 16'(busy_ok), 16'd1);
      check_val($sformatf("%s hold", tag), 16'(hold_ok), 16'd1);
      check_val($sformatf("%s result", tag), 16'(result), 16'(er));
      check_val($sformatf("%s cout", tag), 16'(cout), 16'(ec));
      check_val($sformatf("%s zero", tag), 16'(zero), 16'(er == 8'h00));
      check_val($sformatf("%s neg", tag), 16'(neg), 16'(er[7]));
      check_val($sformatf("%s ovf", tag), 16'(ovf), 16'(ev));
      @(negedge clock);
      check_val($sformatf("%s done pulse", tag), 16'(done), 16'd0);
      check_val($sformatf("%s idle", tag), 16'(busy), 16'd0);
      check_val($sformatf("%s result held", tag), 16'(result), 16'(er));
      prev_res = er;
   endtask

   initial begin
      logic quiet_ok;
      #1;
      check_val("reset busy", 16'(busy), 16'd0);
      check_val("reset done", 16'(done), 16'd0);
      check_val("reset result", 16'(result), 16'h00);
      check_val("reset flags", 16'({cout, zero, neg, ovf}), 16'h0);
      repeat (3) @(negedge clock);
      resetn = 1'b1;

      run_op("add_ff_01", OP_ADD, 8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b0, 0);
      run_op("sub_80_01", OP_SUB, 8'h80, 8'h01, 1'b1, 1, 8'h7F, 1'b1, 1'b1, 0);
      run_op("and",       OP_AND, 8'hF0, 8'h3C, 1'b1, 1, 8'h30, 1'b0, 1'b0, 0);
      run_op("or",        OP_OR,  8'h0F, 8'hA0, 1'b0, 1, 8'hAF, 1'b0, 1'b0, 0);
      run_op("xor",       OP_XOR, 8'hAA, 8'hAA, 1'b1, 1, 8'h00, 1'b0, 1'b0, 0);
      run_op("sub_borrow",OP_SUB, 8'h05, 8'h07, 1'b1, 1, 8'hFE, 1'b0, 1'b0, 0);
      run_op("shl_3",     OP_SHL, 8'h81, 8'h03, 1'b0, 4, 8'h08, 1'b0, 1'b0, 0);
      run_op("shr_1",     OP_SHR, 8'h81, 8'h01, 1'b0, 2, 8'h40, 1'b1, 1'b0, 0);
      run_op("shl_0",     OP_SHL, 8'h81, 8'h08, 1'b0, 1, 8'h81, 1'b0, 1'b0, 0);
      run_op("shr_7",     OP_SHR, 8'hC0, 8'h07, 1'b0, 8, 8'h01, 1'b1, 1'b0, 0);
      run_op("mul_0f_11", OP_MUL, 8'h0F, 8'h11, 1'b0, 9, 8'hFF, 1'b0, 1'b0, 0);
      run_op("mul_10_10", OP_MUL, 8'h10, 8'h10, 1'b0, 9, 8'h00, 1'b1, 1'b1, 0);
      run_op("mul_poke",  OP_MUL, 8'h0F, 8'h11, 1'b0, 9, 8'hFF, 1'b0, 1'b0, 3);
      run_op("add_7f_01", OP_ADD, 8'h7F, 8'h01, 1'b0, 1, 8'h80, 1'b0, 1'b1, 0);

      // Abort a multiply mid-flight with reset.
      @(negedge clock);
      op = OP_MUL; x = 8'h03; y = 8'h05; start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clock);
      check_val("pre-abort busy", 16'(busy), 16'd1);
      resetn = 1'b0;
      #1;
      check_val("abort busy", 16'(busy), 16'd0);
      check_val("abort done", 16'(done), 16'd0);
      check_val("abort result", 16'(result), 16'h00);
      check_val("abort flags", 16'({cout, zero, neg, ovf}), 16'h0);
      quiet_ok = 1'b1;
      repeat (3) begin
         @(negedge clock);
         if (done || busy) quiet_ok = 1'b0;
      end
      resetn = 1'b1;
      repeat (2) begin
         @(negedge clock);
         if (done || busy) quiet_ok = 1'b0;
      end
      check_val("abort no done", 16'(quiet_ok), 16'd1);
      prev_res = 8'h00;
      run_op("add_after_rst", OP_ADD, 8'h02, 8'h03, 1'b0, 1, 8'h05, 1'b0, 1'b0, 0);

      // start held high: accepts every second edge, x changes every cycle.
      @(negedge clock);
      op = OP_ADD; y = 8'h01; cin = 1'b0; x = 8'd20; start = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         @(negedge clock);
         check_val($sformatf("b2b done c%0d", j), 16'(done), 16'(j % 2));
         if (j % 2 == 1) check_val($sformatf("b2b result c%0d", j), 16'(result), 16'(20 + j));
         else            check_val($sformatf("b2b hold c%0d", j), 16'(result), 16'(19 + j));
         x = 8'(20 + j);
      end
      start = 1'b0;
      repeat (3) @(negedge clock);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, multi-cycle successor to the 8-bit combinational ALU in the processor datapath. It supports add/sub, four logic ops, barrel-free iterative shifts, and an iterative shift-add multiply. Operands are latched under a start/done handshake, and the block drives registered result and status flags. It sits between the register-file read ports and the writeback mux; the control FSM stalls on `busy`.

## Interface
- `N`, default 8: operand/result width, N ≥ 4.
- `SW`, default $clog2(N): shift-amount width, derived and not overridden.
- `clock` in, 1 bit: rising-edge clock.
- `resetn` in, 1 bit: asynchronous, active-low reset. The block has one clock; reset is asynchronous and active-low.
- `start` in, 1 bit: request. Sampled only when `busy` = 0.
- `op` in, 3 bits: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL.
- `x`, `y` in, N bits each: operands. For shifts, the amount is s = `y[SW-1:0]`.
- `cin` in, 1 bit: carry-in for ADD/SUB.
- `busy` out, 1 bit: high whenever state ≠ IDLE.
- `done` out, 1 bit: one-cycle pulse; result and flags are valid from this cycle on.
- `result` out, N bits: registered result, held until the next `done`.
- `cout`, `zero`, `neg`, `ovf` out, 1 bit each: registered flags, updated together with `result`.

## Operation
- FSM states:
  - IDLE: on `start`, latch `op`, `x`, `y`, `cin`.
    - ADD through XOR: compute and go directly to DONE.
    - SHL/SHR with s = 0: go directly to DONE.
    - SHL/SHR with s > 0, and MUL: go to EXEC.
  - EXEC: one shift step or one multiply step per cycle, tracked by an iteration counter. When the last step completes, go to DONE.
  - DONE: `done` = 1. Go to IDLE next cycle unconditionally.
- ADD: `result` = x + y + cin (mod 2^N). `cout` = carry out of bit N-1.
- SUB: `result` = x + ~y + cin. Callers drive cin = 1 for a true x − y. `cout` = carry out, where 1 means no borrow.
- `ovf` for ADD/SUB: signed overflow, i.e. operand sign bits equal and result sign different.
- AND/OR/XOR: bitwise. `cout` = 0, `ovf` = 0.
- SHL/SHR: one bit per EXEC cycle, s cycles total, zero fill. `cout` = last bit shifted out, or 0 when s = 0. `ovf` = 0.
- MUL: unsigned shift-add over N EXEC cycles into a 2N-bit accumulator.
  - `result` = low N bits of the product.
  - `cout` = `ovf` = 1 iff the high N bits are nonzero.
- For every op: `zero` = (result == 0) and `neg` = result[N-1].
- `start` while `busy` = 1 is ignored: no queuing, no effect on the running op.
- Changes to `x`, `y`, `op`, or `cin` after acceptance have no effect on the running op.
- `result` and the flags change only at the edge entering DONE. They are never partially updated during EXEC.

## Timing
- Reset: `resetn` low forces the following immediately, independent of `clock`:
  - State returns to IDLE.
  - `busy`, `done`, `result`, `cout`, `zero`, `neg`, `ovf` all go to 0. `zero` resets to 0, not 1.
  - The iteration counter clears.
- Reset mid-EXEC aborts the operation with no `done`. After release, the first accepted `start` behaves normally.
- Latency is measured from the accepting edge k to the `done` cycle:
  - ADD/SUB/logic: `done` in cycle k+1.
  - Shifts: `done` in cycle k+1+s.
  - MUL: `done` in cycle k+1+N.
- `busy` rises in the cycle after the accepting edge and stays high through the `done` cycle.
- Earliest next accept is the edge ending the `done` cycle + 1, so single-cycle ops sustain one op per 2 cycles.
- Shift amount s = N−1 is the maximum (7 cycles of EXEC for N = 8). s is never taken mod anything other than 2^SW.

## Test plan
- ADD x=8'hFF, y=8'h01, cin=0 → `done` at k+1, result=8'h00, cout=1, zero=1, ovf=0, neg=0.
- SUB x=8'h80, y=8'h01, cin=1 → result=8'h7F, cout=1, ovf=1, neg=0. Then AND x=8'hF0, y=8'h3C → result=8'h30, cout=0, ovf=0.
- SHL x=8'h81, y=8'h03 → busy for cycles k+1..k+4, `done` at k+4, result=8'h08, cout=0. SHR x=8'h81, y=8'h01 → result=8'h40, cout=1, `done` at k+2.
- MUL x=8'h0F, y=8'h11 → `done` at k+9, result=8'hFF, cout=0, ovf=0. MUL x=8'h10, y=8'h10 → result=8'h00, zero=1, cout=1, ovf=1.
- MUL in flight; pulse `start` with op=ADD at k+3 → ignored, MUL result unchanged. Drop `resetn` at k+5 → busy, done, result, and all flags go to 0 at once with no `done`. After release, ADD 8'h02+8'h03 → result 8'h05 at +1.
- Back-to-back: hold `start` high with ADD ops → accepts every second edge. `done` pulses exactly one cycle each, and `result` is stable between pulses.
